// File: rtl/multi_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_delay_timer
//  Purpose  : CH independent programmable delay timers. Each channel latches
//             a delay D and a mode on a trigger, counts down, and raises its
//             output D+1 cycles after the trigger edge in one of three styles:
//             LEVEL (hold high until trigger/cancel), PULSE (one cycle high)
//             or PERIODIC (one-cycle pulse every D+1 cycles until cancelled).
//
//  Ports    : clk            - single clock, all state on rising edge
//             reset          - asynchronous active-low reset, released
//                              synchronously through an internal 2-flop stage
//             trigger[CH]    - per-channel start/restart request
//             cancel[CH]     - per-channel abort request (wins over trigger)
//             delay_input    - per-channel delay, channel i at [i*WIDTH +: WIDTH]
//             mode[2*CH]     - per-channel mode, channel i at [2i +: 2]
//                              00 LEVEL, 01 PULSE, 10 PERIODIC, 11 LEVEL
//             delayed_output - per-channel registered timer output
//             busy           - per-channel, high while counting
//             any_expired    - registered OR of last cycle's expiry events
//
//  Revision : 1.0 - initial release
// ============================================================================
module multi_delay_timer #(
  parameter int CH    = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH-1:0]         trigger,
  input  logic [CH-1:0]         cancel,
  input  logic [CH*WIDTH-1:0]   delay_input,
  input  logic [2*CH-1:0]       mode,
  output logic [CH-1:0]         delayed_output,
  output logic [CH-1:0]         busy,
  output logic                  any_expired
);

  localparam logic [1:0] c_MODE_PULSE    = 2'b01;
  localparam logic [1:0] c_MODE_PERIODIC = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Reset conditioning: assertion reaches every flop immediately, release is
  // aligned to clk so no channel sees a partial first edge.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Per-channel one-cycle expiry events, visible the same cycle the output
  // rises; any_expired is this vector ORed and registered once more.
  logic [CH-1:0] w_expired;
  logic          r_any_expired;

  // --------------------------------------------------------------------------
  // Channel instances
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_dly;
    logic [WIDTH-1:0] w_dly_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_exp;
    logic             w_exp_nxt;

    always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_dly   <= '0;
        r_mode  <= 2'b00;
        r_out   <= 1'b0;
        r_exp   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_dly   <= w_dly_nxt;
        r_mode  <= w_mode_nxt;
        r_out   <= w_out_nxt;
        r_exp   <= w_exp_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dly_nxt   = r_dly;
      w_mode_nxt  = r_mode;
      w_out_nxt   = r_out;
      w_exp_nxt   = 1'b0;

      if (cancel[i]) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_out_nxt   = 1'b0;
      end else if (trigger[i]) begin
        // A trigger restarts from any state, so an expiry that would have
        // happened on this same edge is dropped.
        w_dly_nxt   = delay_input[i*WIDTH +: WIDTH];
        w_mode_nxt  = mode[2*i +: 2];
        w_cnt_nxt   = delay_input[i*WIDTH +: WIDTH];
        w_state_nxt = S_COUNT;
        w_out_nxt   = 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Also terminates the single high cycle of a PULSE expiry.
            w_out_nxt = 1'b0;
          end
          S_COUNT: begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
              w_out_nxt = 1'b0;
            end else begin
              w_exp_nxt = 1'b1;
              w_out_nxt = 1'b1;
              if (r_mode == c_MODE_PULSE) begin
                w_state_nxt = S_IDLE;
              end else if (r_mode == c_MODE_PERIODIC) begin
                w_cnt_nxt = r_dly;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
          end
          S_DONE: begin
            w_out_nxt = 1'b1;
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_out_nxt   = 1'b0;
          end
        endcase
      end
    end

    assign delayed_output[i] = r_out;
    assign busy[i]           = (r_state == S_COUNT);
    assign w_expired[i]      = r_exp;
  end

  // --------------------------------------------------------------------------
  // Aggregate expiry flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_any_expired <= 1'b0;
    end else begin
      r_any_expired <= |w_expired;
    end
  end

  assign any_expired = r_any_expired;

endmodule
`default_nettype wire
